decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage. It sits between the fetch stage and the execute stage.
- Decodes the custom 32-bit ISA into field, offset and control signals and holds them in an ID/EX register with a valid bit.
- Detects load-use hazards and inserts bubbles. Honours downstream stall and branch flush.
- Keeps a saturating count of stall cycles.

Parameters:
- XLEN, 32, datapath width; sign-extended offsets are XLEN bits.
- REG_IDX_W, 5, register index width.
- MEM_OFF_W, 15, M-type offset width, taken from instruction[MEM_OFF_W-1:0].
- BRN_SHIFT, 2, left shift applied to the branch offset.
- CNT_W, 16, width of the stall-cycle counter.
- HAZARD_EN, 1, 1 enables load-use detection; 0 disables it (if_stall follows ex_stall only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  instruction input is valid.
- if_instruction  in  32  fetched instruction.
- if_stall  out  1  fetch must hold its instruction this cycle (combinational).
- ex_stall  in  1  execute stage cannot accept; hold the ID/EX register.
- flush  in  1  taken branch or jump; kill the decoded and incoming instruction.
- id_valid  out  1  ID/EX register holds a live instruction.
- id_opcode  out  7  instruction[31:25].
- id_dst_reg, id_src_reg_1, id_src_reg_2  out  REG_IDX_W each  instruction[24:20], [19:15], [14:10].
- id_mem_offset  out  XLEN  sign-extended instruction[MEM_OFF_W-1:0].
- id_brn_offset  out  XLEN  sign-extended {instruction[24:20], instruction[9:0]}, shifted left by BRN_SHIFT.
- id_jmp_offset  out  20  {instruction[24:20], instruction[14:0]}.
- id_alu_imm_src, id_mem_read, id_mem_write, id_mem_byte, id_reg_write, id_mem_to_reg  out  1 each  control flags.
- stall_count  out  CNT_W  saturating count of cycles in which if_stall was high.

Behaviour:
- Reset: all id_* outputs are 0, id_valid is 0 and stall_count is 0. Reset takes effect immediately on assertion, including mid-stall.
- Decode is combinational from if_instruction. The result is registered with 1-cycle latency: an instruction accepted at edge N appears on id_* after edge N.

Control flags by opcode (mem_read, mem_write, mem_byte, reg_write, mem_to_reg):
- ADD, SUB, MUL: 00010.
- LDB: 10101.
- LDW: 10001.
- STB: 01100.
- STW: 01000.
- Any other opcode: 00000.
- alu_imm_src = mem_read OR mem_write.

Hazard detection:
- hazard = HAZARD_EN AND id_valid AND id_mem_read AND if_valid AND (id_dst_reg != 0) AND (id_dst_reg == src1, OR (id_dst_reg == src2 AND the incoming opcode is ADD, SUB, MUL, STB or STW)).
- src1 and src2 are the source fields of the incoming instruction.

if_stall = (ex_stall OR hazard) AND NOT flush.

Register update priority at each edge:
1. flush: id_valid <= 0. Other fields are don't-care and are held.
2. ex_stall: hold all id_* unchanged.
3. hazard: id_valid <= 0 (bubble). Fields are cleared so the control flags read 0.
4. Otherwise: load the decode; id_valid <= if_valid.

Further rules:
- A bubble lasts exactly one cycle. On the next cycle id_mem_read is 0, so the hazard clears.
- Simultaneous flush and ex_stall: flush wins and the register is killed.
- Simultaneous hazard and ex_stall: hold, with no bubble; hazard is re-evaluated next cycle.
- An invalid slot (id_valid = 0) never raises a hazard.
- stall_count increments on each cycle with if_stall = 1 and saturates at all-ones. It never wraps.

Decomposition:
- Opcode constants (OP_ADD … OP_STW) and the 5-bit control-flag vector layout come from the shared parameters include.
- A new constant CTRL_NONE = 5'b00000 is added there.
- One sub-module: decode_comb. It is purely combinational, maps instruction to fields, offsets and flags, and is instantiated once.
- The hazard logic, register and counter live in decode_stage.

Test Plan:
- Reset: assert reset mid-stream with id_valid = 1 -> id_valid = 0 and stall_count = 0 immediately, without waiting for a clock edge.
- Offset extension: instruction with [14:0] = 15'h4000 -> id_mem_offset = 32'hFFFF_C000. Fields [24:20] = 5'h10 and [9:0] = 0 -> id_brn_offset = 32'hFFFF_0000.
- Load-use: LDW r3 followed by ADD r5 = r3 + r1 -> one cycle with if_stall = 1 and a bubble (id_valid = 0), then ADD issues; stall_count = 1.
- No false hazard: LDW r0 followed by ADD using r0 -> no stall. LDW r3 followed by LDW r4 using src2 field = 3 (src2 not used by loads) -> no stall.
- Flush priority: flush = 1 with ex_stall = 1 and a valid instruction in ID -> id_valid = 0 next cycle and if_stall = 0.
- Saturation: CNT_W = 4 with ex_stall held for 20 cycles -> stall_count stops at 4'hF.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared ISA definitions for the decode stage: opcode values, the 5-bit
// control-flag vector layout and small decode helpers.
package decode_stage_pkg;

    localparam int OPCODE_W = 7;

    // Opcode encodings of the custom ISA (instruction[31:25]).
    localparam logic [OPCODE_W-1:0] OP_ADD = 7'h01;
    localparam logic [OPCODE_W-1:0] OP_SUB = 7'h02;
    localparam logic [OPCODE_W-1:0] OP_MUL = 7'h03;
    localparam logic [OPCODE_W-1:0] OP_LDB = 7'h04;
    localparam logic [OPCODE_W-1:0] OP_LDW = 7'h05;
    localparam logic [OPCODE_W-1:0] OP_STB = 7'h06;
    localparam logic [OPCODE_W-1:0] OP_STW = 7'h07;

    // Control-flag vector, MSB first: mem_read, mem_write, mem_byte,
    // reg_write, mem_to_reg.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_byte;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = 5'b00000;
    localparam ctrl_t CTRL_ALU  = 5'b00010;
    localparam ctrl_t CTRL_LDB  = 5'b10101;
    localparam ctrl_t CTRL_LDW  = 5'b10001;
    localparam ctrl_t CTRL_STB  = 5'b01100;
    localparam ctrl_t CTRL_STW  = 5'b01000;

    // Control flags implied by an opcode; unknown opcodes do nothing.
    function automatic ctrl_t ctrl_of(input logic [OPCODE_W-1:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL: return CTRL_ALU;
            OP_LDB:                 return CTRL_LDB;
            OP_LDW:                 return CTRL_LDW;
            OP_STB:                 return CTRL_STB;
            OP_STW:                 return CTRL_STW;
            default:                return CTRL_NONE;
        endcase
    endfunction

    // Loads carry an offset in the src2 field, so only ALU ops and stores
    // actually read a second source register.
    function automatic logic reads_src2(input logic [OPCODE_W-1:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_STB, OP_STW: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: splits a 32-bit instruction into
// register fields, sign-extended offsets and control flags.
module decode_comb
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int MEM_OFF_W = 15,
    parameter int BRN_SHIFT = 2
) (
    input  logic [31:0]          instruction,
    output logic [6:0]           opcode,
    output logic [REG_IDX_W-1:0] dst_reg,
    output logic [REG_IDX_W-1:0] src_reg_1,
    output logic [REG_IDX_W-1:0] src_reg_2,
    output logic [XLEN-1:0]      mem_offset,
    output logic [XLEN-1:0]      brn_offset,
    output logic [19:0]          jmp_offset,
    output logic                 alu_imm_src,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_byte,
    output logic                 reg_write,
    output logic                 mem_to_reg
);

    localparam int BRN_RAW_W = 15;

    logic [BRN_RAW_W-1:0] brn_raw;
    logic [XLEN-1:0]      brn_sext;
    ctrl_t                ctrl;

    assign opcode    = instruction[31:25];
    assign dst_reg   = instruction[20 +: REG_IDX_W];
    assign src_reg_1 = instruction[15 +: REG_IDX_W];
    assign src_reg_2 = instruction[10 +: REG_IDX_W];

    assign mem_offset = {{(XLEN-MEM_OFF_W){instruction[MEM_OFF_W-1]}},
                         instruction[MEM_OFF_W-1:0]};

    // The branch offset is split around the source-register fields.
    assign brn_raw    = {instruction[24:20], instruction[9:0]};
    assign brn_sext   = {{(XLEN-BRN_RAW_W){brn_raw[BRN_RAW_W-1]}}, brn_raw};
    assign brn_offset = brn_sext << BRN_SHIFT;

    assign jmp_offset = {instruction[24:20], instruction[14:0]};

    // Flag lookup from the opcode table.
    // NOTE: every variable written in always_comb gets a value on every path
    // (here via the function's default arm), otherwise a latch is inferred.
    always_comb begin
        ctrl = ctrl_of(opcode);
    end

    assign mem_read    = ctrl.mem_read;
    assign mem_write   = ctrl.mem_write;
    assign mem_byte    = ctrl.mem_byte;
    assign reg_write   = ctrl.reg_write;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign alu_imm_src = ctrl.mem_read | ctrl.mem_write;

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: decodes the fetched instruction into the
// ID/EX register, inserts load-use bubbles, honours execute stall and branch
// flush, and counts stall cycles with saturation.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int MEM_OFF_W = 15,
    parameter int BRN_SHIFT = 2,
    parameter int CNT_W     = 16,
    parameter int HAZARD_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [31:0]          if_instruction,
    output logic                 if_stall,
    input  logic                 ex_stall,
    input  logic                 flush,
    output logic                 id_valid,
    output logic [6:0]           id_opcode,
    output logic [REG_IDX_W-1:0] id_dst_reg,
    output logic [REG_IDX_W-1:0] id_src_reg_1,
    output logic [REG_IDX_W-1:0] id_src_reg_2,
    output logic [XLEN-1:0]      id_mem_offset,
    output logic [XLEN-1:0]      id_brn_offset,
    output logic [19:0]          id_jmp_offset,
    output logic                 id_alu_imm_src,
    output logic                 id_mem_read,
    output logic                 id_mem_write,
    output logic                 id_mem_byte,
    output logic                 id_reg_write,
    output logic                 id_mem_to_reg,
    output logic [CNT_W-1:0]     stall_count
);

    // Decoded view of the incoming instruction.
    logic [6:0]           dec_opcode;
    logic [REG_IDX_W-1:0] dec_dst_reg;
    logic [REG_IDX_W-1:0] dec_src_reg_1;
    logic [REG_IDX_W-1:0] dec_src_reg_2;
    logic [XLEN-1:0]      dec_mem_offset;
    logic [XLEN-1:0]      dec_brn_offset;
    logic [19:0]          dec_jmp_offset;
    logic                 dec_alu_imm_src;
    logic                 dec_mem_read;
    logic                 dec_mem_write;
    logic                 dec_mem_byte;
    logic                 dec_reg_write;
    logic                 dec_mem_to_reg;

    logic hazard;
    logic src1_match;
    logic src2_match;

    decode_comb #(
        .XLEN      (XLEN),
        .REG_IDX_W (REG_IDX_W),
        .MEM_OFF_W (MEM_OFF_W),
        .BRN_SHIFT (BRN_SHIFT)
    ) u_decode_comb (
        .instruction (if_instruction),
        .opcode      (dec_opcode),
        .dst_reg     (dec_dst_reg),
        .src_reg_1   (dec_src_reg_1),
        .src_reg_2   (dec_src_reg_2),
        .mem_offset  (dec_mem_offset),
        .brn_offset  (dec_brn_offset),
        .jmp_offset  (dec_jmp_offset),
        .alu_imm_src (dec_alu_imm_src),
        .mem_read    (dec_mem_read),
        .mem_write   (dec_mem_write),
        .mem_byte    (dec_mem_byte),
        .reg_write   (dec_reg_write),
        .mem_to_reg  (dec_mem_to_reg)
    );

    // Load-use hazard: the load in ID/EX writes a register the incoming
    // instruction reads. r0 is never a real dependency.
    assign src1_match = (id_dst_reg == dec_src_reg_1);
    assign src2_match = (id_dst_reg == dec_src_reg_2) && reads_src2(dec_opcode);

    assign hazard = (HAZARD_EN != 0) && id_valid && id_mem_read && if_valid &&
                    (id_dst_reg != '0) && (src1_match || src2_match);

    // A flush kills whatever fetch holds, so fetch must never be held then.
    assign if_stall = (ex_stall || hazard) && !flush;

    // ID/EX register: flush beats stall, stall beats bubble, bubble beats load.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples its inputs from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid       <= 1'b0;
            id_opcode      <= '0;
            id_dst_reg     <= '0;
            id_src_reg_1   <= '0;
            id_src_reg_2   <= '0;
            id_mem_offset  <= '0;
            id_brn_offset  <= '0;
            id_jmp_offset  <= '0;
            id_alu_imm_src <= 1'b0;
            id_mem_read    <= 1'b0;
            id_mem_write   <= 1'b0;
            id_mem_byte    <= 1'b0;
            id_reg_write   <= 1'b0;
            id_mem_to_reg  <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (ex_stall) begin
            id_valid <= id_valid;
        end else if (hazard) begin
            // Bubble: clearing the flags guarantees the hazard drops next cycle.
            id_valid       <= 1'b0;
            id_opcode      <= '0;
            id_dst_reg     <= '0;
            id_src_reg_1   <= '0;
            id_src_reg_2   <= '0;
            id_mem_offset  <= '0;
            id_brn_offset  <= '0;
            id_jmp_offset  <= '0;
            id_alu_imm_src <= 1'b0;
            id_mem_read    <= 1'b0;
            id_mem_write   <= 1'b0;
            id_mem_byte    <= 1'b0;
            id_reg_write   <= 1'b0;
            id_mem_to_reg  <= 1'b0;
        end else begin
            id_valid       <= if_valid;
            id_opcode      <= dec_opcode;
            id_dst_reg     <= dec_dst_reg;
            id_src_reg_1   <= dec_src_reg_1;
            id_src_reg_2   <= dec_src_reg_2;
            id_mem_offset  <= dec_mem_offset;
            id_brn_offset  <= dec_brn_offset;
            id_jmp_offset  <= dec_jmp_offset;
            id_alu_imm_src <= dec_alu_imm_src;
            id_mem_read    <= dec_mem_read;
            id_mem_write   <= dec_mem_write;
            id_mem_byte    <= dec_mem_byte;
            id_reg_write   <= dec_reg_write;
            id_mem_to_reg  <= dec_mem_to_reg;
        end
    end

    // Saturating stall-cycle counter; it sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (if_stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised self-checking bench for decode_stage, checked against a
// behavioural pipeline-slot model, plus directed boundary cases.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic        ex_stall;
    logic        flush;

    logic        if_stall, id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_dst_reg, id_src_reg_1, id_src_reg_2;
    logic [31:0] id_mem_offset, id_brn_offset;
    logic [19:0] id_jmp_offset;
    logic        id_alu_imm_src, id_mem_read, id_mem_write, id_mem_byte;
    logic        id_reg_write, id_mem_to_reg;
    logic [15:0] stall_count;

    logic        s_if_stall, s_id_valid;
    logic [6:0]  s_id_opcode;
    logic [4:0]  s_id_dst_reg, s_id_src_reg_1, s_id_src_reg_2;
    logic [31:0] s_id_mem_offset, s_id_brn_offset;
    logic [19:0] s_id_jmp_offset;
    logic        s_id_alu_imm_src, s_id_mem_read, s_id_mem_write, s_id_mem_byte;
    logic        s_id_reg_write, s_id_mem_to_reg;
    logic [3:0]  s_stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the ID/EX slot: the instruction it holds, whether it is live,
    // and whether its fields are defined (they are not after a flush).
    bit          m_valid;
    bit          m_known;
    logic [31:0] m_instr;
    int          m_cnt;
    logic        seen_stall;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instruction(if_instruction),
        .if_stall(if_stall), .ex_stall(ex_stall), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_dst_reg(id_dst_reg), .id_src_reg_1(id_src_reg_1),
        .id_src_reg_2(id_src_reg_2), .id_mem_offset(id_mem_offset),
        .id_brn_offset(id_brn_offset), .id_jmp_offset(id_jmp_offset),
        .id_alu_imm_src(id_alu_imm_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_byte(id_mem_byte),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .stall_count(stall_count)
    );

    decode_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instruction(if_instruction),
        .if_stall(s_if_stall), .ex_stall(ex_stall), .flush(flush), .id_valid(s_id_valid),
        .id_opcode(s_id_opcode), .id_dst_reg(s_id_dst_reg), .id_src_reg_1(s_id_src_reg_1),
        .id_src_reg_2(s_id_src_reg_2), .id_mem_offset(s_id_mem_offset),
        .id_brn_offset(s_id_brn_offset), .id_jmp_offset(s_id_jmp_offset),
        .id_alu_imm_src(s_id_alu_imm_src), .id_mem_read(s_id_mem_read),
        .id_mem_write(s_id_mem_write), .id_mem_byte(s_id_mem_byte),
        .id_reg_write(s_id_reg_write), .id_mem_to_reg(s_id_mem_to_reg),
        .stall_count(s_stall_count)
    );

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] dst,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [9:0] low);
        return {op, dst, s1, s2, low};
    endfunction

    // Flags {mem_read, mem_write, mem_byte, reg_write, mem_to_reg} from the opcode table.
    function automatic logic [4:0] flags_of(input logic [6:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_MUL) return 5'b00010;
        if (op == OP_LDB) return 5'b10101;
        if (op == OP_LDW) return 5'b10001;
        if (op == OP_STB) return 5'b01100;
        if (op == OP_STW) return 5'b01000;
        return 5'b00000;
    endfunction

    function automatic bit uses_src2(input logic [6:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_MUL || op == OP_STB || op == OP_STW;
    endfunction

    // Two's-complement value of a 15-bit field.
    function automatic int sx15(input logic [14:0] v);
        int r;
        r = int'(v);
        if (r >= 16384) r = r - 32768;
        return r;
    endfunction

    function automatic bit model_hazard(input bit v_in, input logic [31:0] ins);
        logic [4:0] fl;
        logic [4:0] dst;
        fl  = flags_of(m_instr[31:25]);
        dst = m_instr[24:20];
        return m_valid && fl[4] && v_in && (dst != 0) &&
               (dst == ins[19:15] || (dst == ins[14:10] && uses_src2(ins[31:25])));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_known = 1'b1;
        m_instr = '0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        logic [4:0]  fl;
        logic [31:0] mo, bo;
        int          sat;
        check("id_valid", id_valid, m_valid);
        check("stall_count", stall_count, m_cnt);
        sat = (m_cnt > 15) ? 15 : m_cnt;
        check("stall_count_sat", s_stall_count, sat);
        if (m_known) begin
            fl = flags_of(m_instr[31:25]);
            mo = 32'(sx15(m_instr[14:0]));
            bo = 32'(sx15({m_instr[24:20], m_instr[9:0]}) * 4);
            check("opcode", id_opcode, m_instr[31:25]);
            check("dst", id_dst_reg, m_instr[24:20]);
            check("src1", id_src_reg_1, m_instr[19:15]);
            check("src2", id_src_reg_2, m_instr[14:10]);
            check("mem_off", id_mem_offset, mo);
            check("brn_off", id_brn_offset, bo);
            check("jmp_off", id_jmp_offset, {m_instr[24:20], m_instr[14:0]});
            check("flags", {id_mem_read, id_mem_write, id_mem_byte, id_reg_write, id_mem_to_reg}, fl);
            check("alu_imm", id_alu_imm_src, fl[4] | fl[3]);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational stall away from
    // the edge, then advance the model and check the registered outputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic es, input logic fl);
        bit hz, stall;
        if_valid       = v;
        if_instruction = ins;
        ex_stall       = es;
        flush          = fl;
        @(negedge clk);
        hz    = model_hazard(v, ins);
        stall = (es || hz) && !fl;
        seen_stall = if_stall;
        check("if_stall", if_stall, stall);
        @(posedge clk);
        #1;
        if (stall && m_cnt < 65535) m_cnt++;
        if (fl) begin
            m_valid = 1'b0;
            m_known = 1'b0;
        end else if (es) begin
            // held
        end else if (hz) begin
            m_valid = 1'b0;
            m_instr = '0;
            m_known = 1'b1;
        end else begin
            m_valid = v;
            m_instr = ins;
            m_known = 1'b1;
        end
        check_outputs();
    endtask

    initial begin
        int          c0;
        logic [31:0] ins;
        logic        v;
        bit          held;
        logic [6:0]  ops [8];

        reset = 1'b1;
        if_valid = 1'b0;
        if_instruction = '0;
        ex_stall = 1'b0;
        flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Offset sign extension.
        step(1'b1, mk(OP_ADD, 5'h10, 5'h00, 5'h10, 10'h000), 1'b0, 1'b0);
        check("mem_off_dir", id_mem_offset, 32'hFFFF_C000);
        check("brn_off_dir", id_brn_offset, 32'hFFFF_0000);

        // Load-use: LDW r3 then ADD r5 = r3 + r1.
        c0 = m_cnt;
        step(1'b1, mk(OP_LDW, 5'd3, 5'd1, 5'd0, 10'h004), 1'b0, 1'b0);
        step(1'b1, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 10'h000), 1'b0, 1'b0);
        check("lu_stall", seen_stall, 1'b1);
        check("lu_bubble", id_valid, 1'b0);
        step(1'b1, mk(OP_ADD, 5'd5, 5'd3, 5'd1, 10'h000), 1'b0, 1'b0);
        check("lu_issue", id_valid, 1'b1);
        check("lu_count", stall_count, c0 + 1);

        // No false hazards: r0 destination; src2 of a load.
        step(1'b1, mk(OP_LDW, 5'd0, 5'd1, 5'd0, 10'h000), 1'b0, 1'b0);
        step(1'b1, mk(OP_ADD, 5'd6, 5'd0, 5'd0, 10'h000), 1'b0, 1'b0);
        check("r0_nostall", seen_stall, 1'b0);
        step(1'b1, mk(OP_LDW, 5'd3, 5'd1, 5'd0, 10'h000), 1'b0, 1'b0);
        step(1'b1, mk(OP_LDW, 5'd4, 5'd1, 5'd3, 10'h000), 1'b0, 1'b0);
        check("ld_src2_nostall", seen_stall, 1'b0);

        // Flush beats ex_stall.
        step(1'b1, mk(OP_SUB, 5'd7, 5'd2, 5'd2, 10'h000), 1'b0, 1'b0);
        step(1'b1, mk(OP_MUL, 5'd8, 5'd2, 5'd2, 10'h000), 1'b1, 1'b1);
        check("flush_stall", seen_stall, 1'b0);
        check("flush_kill", id_valid, 1'b0);

        // Asynchronous reset mid-stream with a live instruction.
        step(1'b1, mk(OP_STW, 5'd9, 5'd2, 5'd4, 10'h010), 1'b0, 1'b0);
        check("pre_reset_valid", id_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", id_valid, 1'b0);
        check("async_rst_count", stall_count, 16'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Saturation: 20 stalled cycles.
        for (int i = 0; i < 20; i++)
            step(1'b1, mk(OP_ADD, 5'd1, 5'd2, 5'd3, 10'h000), 1'b1, 1'b0);
        check("sat_stop", s_stall_count, 4'hF);
        check("nosat_count", stall_count, 16'd20);

        // Randomised traffic, small register range to provoke hazards.
        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW, 7'h55};
        held = 1'b0;
        ins = '0;
        v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                ins = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         10'($urandom));
                v = ($urandom_range(0, 9) < 8);
            end
            step(v, ins, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            held = seen_stall;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
